stage_mem: RTL and testbench

Memory-access stage directly downstream of the execute stage in the 5-stage LoongArch pipeline. It latches the execute-stage results and drives the data SRAM-like bus with a req/addr_ok/data_ok handshake. For loads it aligns and extends the returned word. It reports completion to the stage controller and passes its result, destination and exception state on to the writeback stage.

---
 rtl/stage_mem.sv | 267 ++++++++++++++++++++++++++
 tb/tb_stage_mem.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// stage_mem: memory-access stage of the 5-stage LoongArch pipeline.
// Latches execute-stage results, runs the data SRAM req/addr_ok/data_ok
// handshake, aligns and extends load data, and hands results to writeback.
// Optional forwarding outputs are enabled by defining MEM_FWD_EN.
module stage_mem #(
  parameter int WIDTH   = 32,
  parameter int ECODE_W = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pipe_tonext_valid_EX,
  input  logic               pipe_valid_MEM,
  input  logic               flush,
  input  logic [WIDTH-1:0]   pc_EX,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [WIDTH-1:0]   rkd_value,
  input  logic [4:0]         dest,
  input  logic               byte_we,
  input  logic               half_we,
  input  logic               word_we,
  input  logic               signed_we,
  input  logic               res_from_mem,
  input  logic               mem_we,
  input  logic               gpr_we,
  input  logic [ECODE_W-1:0] ecode_EX_m,
  input  logic               EX_ex_ertn,
  output logic               data_sram_req,
  output logic               data_sram_wr,
  output logic [1:0]         data_sram_size,
  output logic [3:0]         data_sram_wstrb,
  output logic [WIDTH-1:0]   data_sram_addr,
  output logic [WIDTH-1:0]   data_sram_wdata,
  input  logic               data_sram_addr_ok,
  input  logic               data_sram_data_ok,
  input  logic [WIDTH-1:0]   data_sram_rdata,
  output logic               mem_done,
  output logic [WIDTH-1:0]   pc_MEM,
  output logic [WIDTH-1:0]   final_result_MEM,
  output logic [4:0]         dest_MEM,
  output logic               gpr_we_MEM,
  output logic [ECODE_W-1:0] ecode_MEM,
  output logic               MEM_ex_ertn
`ifdef MEM_FWD_EN
  ,
  output logic               fwd_valid,
  output logic [4:0]         fwd_dest,
  output logic [WIDTH-1:0]   fwd_data,
  output logic               fwd_load_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_CANCEL
  } state_t;

  state_t               state;
  logic                 first_mem;
  logic                 req_q;
  logic                 done_q;
  logic [WIDTH-1:0]     rdata_q;

  logic [WIDTH-1:0]     pc_q;
  logic [WIDTH-1:0]     alu_q;
  logic [WIDTH-1:0]     rkd_q;
  logic [4:0]           dest_q;
  logic                 byte_q;
  logic                 half_q;
  logic                 word_q;
  logic                 signed_q;
  logic                 res_from_mem_q;
  logic                 mem_we_q;
  logic                 gpr_we_q;
  logic [ECODE_W-1:0]   ecode_q;
  logic                 ex_ertn_q;

  logic                 mem_access;
  logic [WIDTH-1:0]     rdata_shifted;
  logic [15:0]          rdata_half;
  logic [WIDTH-1:0]     load_result;

  assign mem_access = pipe_valid_MEM && (res_from_mem_q || mem_we_q)
                      && !ex_ertn_q && !flush;

  // Capture the EX->MEM payload whenever the previous stage hands over.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q           <= '0;
      alu_q          <= '0;
      rkd_q          <= '0;
      dest_q         <= '0;
      byte_q         <= 1'b0;
      half_q         <= 1'b0;
      word_q         <= 1'b0;
      signed_q       <= 1'b0;
      res_from_mem_q <= 1'b0;
      mem_we_q       <= 1'b0;
      gpr_we_q       <= 1'b0;
      ecode_q        <= '0;
      ex_ertn_q      <= 1'b0;
    end else if (pipe_tonext_valid_EX) begin
      pc_q           <= pc_EX;
      alu_q          <= alu_result;
      rkd_q          <= rkd_value;
      dest_q         <= dest;
      byte_q         <= byte_we;
      half_q         <= half_we;
      word_q         <= word_we;
      signed_q       <= signed_we;
      res_from_mem_q <= res_from_mem;
      mem_we_q       <= mem_we;
      gpr_we_q       <= gpr_we;
      ecode_q        <= ecode_EX_m;
      ex_ertn_q      <= EX_ex_ertn;
    end
  end

  // One-cycle marker that a fresh instruction has just been captured.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      first_mem <= 1'b0;
    end else begin
      first_mem <= pipe_tonext_valid_EX;
    end
  end

  // Bus handshake FSM with registered req/done and load-data capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (first_mem) begin
            if (mem_access) begin
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (flush) begin
            // Once addr_ok is seen the response is owed and must be drained.
            state <= data_sram_addr_ok ? S_CANCEL : S_IDLE;
            req_q <= 1'b0;
          end else if (data_sram_addr_ok) begin
            state <= S_WAIT;
            req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (data_sram_data_ok) begin
            // A flush coinciding with data_ok has nothing left to drain.
            if (flush) begin
              state <= S_IDLE;
            end else begin
              state  <= S_DONE;
              done_q <= 1'b1;
              if (res_from_mem_q) begin
                rdata_q <= data_sram_rdata;
              end
            end
          end else if (flush) begin
            state <= S_CANCEL;
          end
        end
        S_DONE: begin
          if (pipe_tonext_valid_EX) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
          end
        end
        S_CANCEL: begin
          if (data_sram_data_ok) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          req_q  <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_sram_req  = req_q;
  assign mem_done       = done_q;
  assign data_sram_wr   = mem_we_q;
  assign data_sram_addr = alu_q;

  // Access size from the latched width flags; word when nothing is set.
  always_comb begin
    data_sram_size = 2'd2;
    if (word_q) begin
      data_sram_size = 2'd2;
    end else if (half_q) begin
      data_sram_size = 2'd1;
    end else if (byte_q) begin
      data_sram_size = 2'd0;
    end
  end

  // Store data replication and byte strobes; loads drive no strobes.
  always_comb begin
    data_sram_wstrb = '0;
    data_sram_wdata = rkd_q;
    case (data_sram_size)
      2'd0: begin
        data_sram_wdata = {(WIDTH/8){rkd_q[7:0]}};
        if (mem_we_q) begin
          data_sram_wstrb = 4'b0001 << alu_q[1:0];
        end
      end
      2'd1: begin
        data_sram_wdata = {(WIDTH/16){rkd_q[15:0]}};
        if (mem_we_q) begin
          data_sram_wstrb = alu_q[1] ? 4'b1100 : 4'b0011;
        end
      end
      default: begin
        data_sram_wdata = rkd_q;
        if (mem_we_q) begin
          data_sram_wstrb = 4'b1111;
        end
      end
    endcase
  end

  // Load alignment by address offset and sign/zero extension.
  always_comb begin
    rdata_shifted = rdata_q >> {alu_q[1:0], 3'b000};
    rdata_half    = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (data_sram_size)
      2'd0:    load_result = {{(WIDTH-8){signed_q & rdata_shifted[7]}},
                              rdata_shifted[7:0]};
      2'd1:    load_result = {{(WIDTH-16){signed_q & rdata_half[15]}},
                              rdata_half};
      default: load_result = rdata_q;
    endcase
  end

  assign pc_MEM           = pc_q;
  assign final_result_MEM = res_from_mem_q ? load_result : alu_q;
  assign dest_MEM         = dest_q;
  assign gpr_we_MEM       = gpr_we_q && !ex_ertn_q;
  assign ecode_MEM        = ecode_q;
  assign MEM_ex_ertn      = pipe_valid_MEM && ex_ertn_q;

`ifdef MEM_FWD_EN
  assign fwd_valid      = pipe_valid_MEM && gpr_we_MEM && (dest_q != 5'd0)
                          && (!res_from_mem_q || state == S_DONE);
  assign fwd_dest       = dest_q;
  assign fwd_data       = final_result_MEM;
  assign fwd_load_stall = pipe_valid_MEM && res_from_mem_q && (state != S_DONE);
`endif

endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: self-checking bench for stage_mem (default build, no forwarding ports).
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pipe_tonext_valid_EX;
  logic        pipe_valid_MEM;
  logic        flush;
  logic [31:0] pc_EX, alu_result, rkd_value;
  logic [4:0]  dest;
  logic        byte_we, half_we, word_we, signed_we;
  logic        res_from_mem, mem_we, gpr_we;
  logic [5:0]  ecode_EX_m;
  logic        EX_ex_ertn;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_done;
  logic [31:0] pc_MEM, final_result_MEM;
  logic [4:0]  dest_MEM;
  logic        gpr_we_MEM;
  logic [5:0]  ecode_MEM;
  logic        MEM_ex_ertn;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stage_mem #(.WIDTH(32), .ECODE_W(6)) dut (
    .clk(clk), .resetn(resetn),
    .pipe_tonext_valid_EX(pipe_tonext_valid_EX), .pipe_valid_MEM(pipe_valid_MEM),
    .flush(flush), .pc_EX(pc_EX), .alu_result(alu_result), .rkd_value(rkd_value),
    .dest(dest), .byte_we(byte_we), .half_we(half_we), .word_we(word_we),
    .signed_we(signed_we), .res_from_mem(res_from_mem), .mem_we(mem_we),
    .gpr_we(gpr_we), .ecode_EX_m(ecode_EX_m), .EX_ex_ertn(EX_ex_ertn),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .mem_done(mem_done), .pc_MEM(pc_MEM),
    .final_result_MEM(final_result_MEM), .dest_MEM(dest_MEM),
    .gpr_we_MEM(gpr_we_MEM), .ecode_MEM(ecode_MEM), .MEM_ex_ertn(MEM_ex_ertn)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] rkd;
    logic [31:0] rdata;
    logic [4:0]  dest;
    int          sz;
    bit          sgn, ld, st, gwe, exr;
    logic [5:0]  ec;
    int          aok, dok;
  } txn_t;

  // Observations from the last bus run.
  int          o_req, o_done;
  bit          o_unst;
  logic        o_wr;
  logic [1:0]  o_size;
  logic [3:0]  o_wstrb;
  logic [31:0] o_addr, o_wdata;
  // Model of the last load word accepted by the stage.
  logic [31:0] last_rd;

  // Reference rules: extract byte/half at offset, extend by sign flag.
  function automatic logic [31:0] model_load(logic [31:0] rd, int off, int sz, bit sgn);
    longint r, v, span;
    if (sz == 2) return rd;
    r    = longint'(rd);
    span = (sz == 0) ? 256 : 65536;
    v    = (r >> (off * 8)) % span;
    if (sgn && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_wstrb(int sz, int off);
    int m;
    m = ((1 << (1 << sz)) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(logic [31:0] rkd, int sz);
    longint r, v;
    r = longint'(rkd);
    if (sz == 0) v = (r % 256) * 64'h01010101;
    else if (sz == 1) v = (r % 65536) * 64'h00010001;
    else v = r;
    return v[31:0];
  endfunction

  function automatic txn_t mk(logic [31:0] addr, logic [31:0] rkd, logic [31:0] rdata,
                              int sz, bit sgn, bit ld, bit st, int aok, int dok);
    txn_t t;
    t.pc = 32'h1c00_0000 + addr; t.addr = addr; t.rkd = rkd; t.rdata = rdata;
    t.dest = 5'd7; t.sz = sz; t.sgn = sgn; t.ld = ld; t.st = st;
    t.gwe = !st; t.exr = 1'b0; t.ec = 6'd0; t.aok = aok; t.dok = dok;
    return t;
  endfunction

  task automatic drive_capture(input txn_t t);
    @(negedge clk);
    pc_EX = t.pc; alu_result = t.addr; rkd_value = t.rkd; dest = t.dest;
    byte_we = (t.ld || t.st) && t.sz == 0;
    half_we = (t.ld || t.st) && t.sz == 1;
    word_we = (t.ld || t.st) && t.sz == 2;
    signed_we = t.sgn; res_from_mem = t.ld; mem_we = t.st; gpr_we = t.gwe;
    ecode_EX_m = t.ec; EX_ex_ertn = t.exr;
    pipe_tonext_valid_EX = 1'b1;
    @(negedge clk);
    pipe_tonext_valid_EX = 1'b0;
  endtask

  // Memory responder: addr_ok after t.aok extra req cycles, data_ok t.dok cycles later.
  task automatic run_bus(input txn_t t);
    int phase, wcnt;
    phase = 0; wcnt = 0; o_req = 0; o_done = -1; o_unst = 1'b0;
    for (int n = 0; n < 60; n++) begin
      data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
      if (mem_done) begin o_done = n; break; end
      if (data_sram_req) begin
        if (o_req == 0) begin
          o_wr = data_sram_wr; o_size = data_sram_size; o_wstrb = data_sram_wstrb;
          o_addr = data_sram_addr; o_wdata = data_sram_wdata;
        end else if (o_addr !== data_sram_addr || o_wr !== data_sram_wr ||
                     o_wstrb !== data_sram_wstrb || o_wdata !== data_sram_wdata) begin
          o_unst = 1'b1;
        end
        o_req++;
      end
      if (phase == 0 && data_sram_req && o_req > t.aok) begin
        data_sram_addr_ok = 1'b1; phase = 1;
      end else if (phase == 1) begin
        wcnt++;
        if (wcnt > t.dok) begin
          data_sram_data_ok = 1'b1; data_sram_rdata = t.rdata; phase = 2;
        end
      end
      @(negedge clk);
    end
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    if (t.ld && !t.exr) last_rd = t.rdata;
  endtask

  task automatic do_txn(input txn_t t);
    drive_capture(t);
    run_bus(t);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data_sram_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", data_sram_req); end
    checks++; if (mem_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", mem_done); end
    checks++; if (pc_MEM !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=0", pc_MEM); end
    checks++; if (final_result_MEM !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=0", final_result_MEM); end
    checks++; if (dest_MEM !== 5'd0 || ecode_MEM !== 6'd0 || gpr_we_MEM !== 1'b0 || MEM_ex_ertn !== 1'b0) begin
      failures++; $display("FAIL reset_misc got dest=%0d ecode=%0d gwe=%b exr=%b want all 0", dest_MEM, ecode_MEM, gpr_we_MEM, MEM_ex_ertn); end
    resetn = 1'b1; pipe_valid_MEM = 1'b1; last_rd = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    txn_t t;
    t = mk(32'h1000, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 1'b1, 1'b0, 0, 1);
    do_txn(t);
    checks++; if (o_req !== 1) begin failures++; $display("FAIL ldw_req_cycles got=%0d want=1", o_req); end
    checks++; if (o_done !== 4) begin failures++; $display("FAIL ldw_done_cycle got=%0d want=4", o_done); end
    checks++; if (final_result_MEM !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ldw_result got=%h want=deadbeef", final_result_MEM); end
    checks++; if (o_wr !== 1'b0 || o_size !== 2'd2 || o_wstrb !== 4'h0 || o_addr !== 32'h1000) begin
      failures++; $display("FAIL ldw_bus got wr=%b size=%0d wstrb=%h addr=%h want 0/2/0/1000", o_wr, o_size, o_wstrb, o_addr); end
  endtask

  task automatic test_load_ext();
    txn_t t;
    t = mk(32'h1003, 32'h0, 32'h80FF_FF12, 0, 1'b1, 1'b1, 1'b0, 1, 0);
    do_txn(t);
    checks++; if (final_result_MEM !== 32'hFFFF_FF80) begin failures++; $display("FAIL ldb_result got=%h want=ffffff80", final_result_MEM); end
    t = mk(32'h1002, 32'h0, 32'h80FF_FF12, 1, 1'b0, 1'b1, 1'b0, 0, 0);
    do_txn(t);
    checks++; if (final_result_MEM !== 32'h0000_80FF) begin failures++; $display("FAIL ldhu_result got=%h want=000080ff", final_result_MEM); end
    checks++; if (o_size !== 2'd1) begin failures++; $display("FAIL ldhu_size got=%0d want=1", o_size); end
  endtask

  task automatic test_store();
    txn_t t;
    t = mk(32'h2002, 32'h1234_ABCD, 32'h0, 1, 1'b0, 1'b0, 1'b1, 0, 0);
    do_txn(t);
    checks++; if (o_wr !== 1'b1 || o_size !== 2'd1 || o_wstrb !== 4'b1100 || o_wdata !== 32'hABCD_ABCD) begin
      failures++; $display("FAIL sth_bus got wr=%b size=%0d wstrb=%b wdata=%h want 1/1/1100/abcdabcd", o_wr, o_size, o_wstrb, o_wdata); end
    checks++; if (gpr_we_MEM !== 1'b0) begin failures++; $display("FAIL sth_gpr_we got=%b want=0", gpr_we_MEM); end
    t = mk(32'h2001, 32'h1234_ABCD, 32'h0, 0, 1'b0, 1'b0, 1'b1, 2, 1);
    do_txn(t);
    checks++; if (o_wstrb !== 4'b0010 || o_wdata !== 32'hCDCD_CDCD) begin
      failures++; $display("FAIL stb_bus got wstrb=%b wdata=%h want 0010/cdcdcdcd", o_wstrb, o_wdata); end
    checks++; if (o_req !== 3 || o_done !== 6) begin failures++; $display("FAIL stb_timing got req=%0d done=%0d want 3/6", o_req, o_done); end
  endtask

  task automatic test_alu();
    txn_t t;
    t = mk(32'h55, 32'h0, 32'h0, 2, 1'b0, 1'b0, 1'b0, 0, 0);
    t.dest = 5'd12;
    do_txn(t);
    checks++; if (o_req !== 0) begin failures++; $display("FAIL alu_req got=%0d want=0", o_req); end
    checks++; if (o_done !== 1) begin failures++; $display("FAIL alu_done_cycle got=%0d want=1", o_done); end
    checks++; if (final_result_MEM !== 32'h55 || dest_MEM !== 5'd12 || gpr_we_MEM !== 1'b1) begin
      failures++; $display("FAIL alu_result got=%h dest=%0d gwe=%b want 55/12/1", final_result_MEM, dest_MEM, gpr_we_MEM); end
  endtask

  task automatic test_flush_req();
    txn_t t;
    t = mk(32'h3000, 32'h0, 32'h0, 2, 1'b0, 1'b1, 1'b0, 0, 0);
    drive_capture(t);
    @(negedge clk);
    checks++; if (data_sram_req !== 1'b1) begin failures++; $display("FAIL flreq_req_up got=%b want=1", data_sram_req); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (data_sram_req !== 1'b0 || mem_done !== 1'b0) begin
      failures++; $display("FAIL flreq_drop got req=%b done=%b want 0/0", data_sram_req, mem_done); end
    @(negedge clk);
    checks++; if (data_sram_req !== 1'b0 || mem_done !== 1'b0) begin
      failures++; $display("FAIL flreq_idle got req=%b done=%b want 0/0", data_sram_req, mem_done); end
  endtask

  task automatic test_flush_wait();
    txn_t t;
    t = mk(32'h3000, 32'h0, 32'h0, 2, 1'b0, 1'b1, 1'b0, 0, 0);
    drive_capture(t);
    @(negedge clk);
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    data_sram_addr_ok = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (mem_done !== 1'b0 || data_sram_req !== 1'b0) begin
        failures++; $display("FAIL cancel_hold%0d got done=%b req=%b want 0/0", k, mem_done, data_sram_req); end
      @(negedge clk);
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    checks++; if (mem_done !== 1'b0 || data_sram_req !== 1'b0) begin
      failures++; $display("FAIL cancel_exit got done=%b req=%b want 0/0", mem_done, data_sram_req); end
    checks++; if (final_result_MEM !== last_rd) begin
      failures++; $display("FAIL cancel_discard got=%h want=%h", final_result_MEM, last_rd); end
    t = mk(32'h3004, 32'h0, 32'h2222_2222, 2, 1'b0, 1'b1, 1'b0, 1, 2);
    do_txn(t);
    checks++; if (o_done !== 6 || final_result_MEM !== 32'h2222_2222) begin
      failures++; $display("FAIL after_cancel got done=%0d result=%h want 6/22222222", o_done, final_result_MEM); end
  endtask

  task automatic test_exception();
    txn_t t;
    t = mk(32'h1001, 32'h0, 32'h0, 2, 1'b0, 1'b1, 1'b0, 0, 0);
    t.exr = 1'b1; t.ec = 6'h9;
    do_txn(t);
    checks++; if (o_req !== 0 || o_done !== 1) begin failures++; $display("FAIL exc_timing got req=%0d done=%0d want 0/1", o_req, o_done); end
    checks++; if (ecode_MEM !== 6'h9 || MEM_ex_ertn !== 1'b1 || gpr_we_MEM !== 1'b0) begin
      failures++; $display("FAIL exc_state got ecode=%h exr=%b gwe=%b want 9/1/0", ecode_MEM, MEM_ex_ertn, gpr_we_MEM); end
  endtask

  task automatic test_reset_in_req();
    txn_t t;
    t = mk(32'h4000, 32'h0, 32'h0, 2, 1'b0, 1'b1, 1'b0, 0, 0);
    drive_capture(t);
    @(negedge clk);
    checks++; if (data_sram_req !== 1'b1) begin failures++; $display("FAIL rstreq_up got=%b want=1", data_sram_req); end
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (data_sram_req !== 1'b0 || mem_done !== 1'b0 || pc_MEM !== 32'h0 || final_result_MEM !== 32'h0) begin
      failures++; $display("FAIL rstreq_clear got req=%b done=%b pc=%h res=%h want 0/0/0/0", data_sram_req, mem_done, pc_MEM, final_result_MEM); end
    resetn = 1'b1; last_rd = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_random();
    txn_t t;
    int kind, exp_done, exp_req;
    logic [31:0] exp_res;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 6);
      t.pc = $urandom; t.rkd = $urandom; t.rdata = $urandom;
      t.dest = 5'($urandom_range(0, 31)); t.sgn = 1'($urandom_range(0, 1));
      t.ld = (kind <= 2); t.st = (kind >= 3 && kind <= 5);
      t.sz = (kind == 6) ? 2 : kind % 3;
      t.addr = $urandom & ~(32'((1 << t.sz) - 1));
      t.gwe = !t.st; t.exr = 1'b0; t.ec = 6'd0;
      t.aok = $urandom_range(0, 3); t.dok = $urandom_range(0, 3);
      do_txn(t);
      exp_req  = (t.ld || t.st) ? t.aok + 1 : 0;
      exp_done = (t.ld || t.st) ? t.aok + t.dok + 3 : 1;
      exp_res  = t.ld ? model_load(t.rdata, int'(t.addr[1:0]), t.sz, t.sgn) : t.addr;
      checks++; if (o_req !== exp_req || o_done !== exp_done) begin
        failures++; $display("FAIL rnd%0d_timing got req=%0d done=%0d want %0d/%0d", i, o_req, o_done, exp_req, exp_done); end
      checks++; if (final_result_MEM !== exp_res) begin
        failures++; $display("FAIL rnd%0d_result got=%h want=%h", i, final_result_MEM, exp_res); end
      checks++; if (pc_MEM !== t.pc || dest_MEM !== t.dest || gpr_we_MEM !== t.gwe || MEM_ex_ertn !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_payload got pc=%h dest=%0d gwe=%b exr=%b want %h/%0d/%b/0", i, pc_MEM, dest_MEM, gpr_we_MEM, MEM_ex_ertn, t.pc, t.dest, t.gwe); end
      if (t.ld || t.st) begin
        checks++; if (o_wr !== t.st || o_size !== 2'(t.sz) || o_addr !== t.addr || o_unst !== 1'b0) begin
          failures++; $display("FAIL rnd%0d_bus got wr=%b size=%0d addr=%h unstable=%b want %b/%0d/%h/0", i, o_wr, o_size, o_addr, o_unst, t.st, t.sz, t.addr); end
        checks++; if (o_wstrb !== (t.st ? model_wstrb(t.sz, int'(t.addr[1:0])) : 4'h0)) begin
          failures++; $display("FAIL rnd%0d_wstrb got=%b want=%b", i, o_wstrb, t.st ? model_wstrb(t.sz, int'(t.addr[1:0])) : 4'h0); end
        if (t.st) begin
          checks++; if (o_wdata !== model_wdata(t.rkd, t.sz)) begin
            failures++; $display("FAIL rnd%0d_wdata got=%h want=%h", i, o_wdata, model_wdata(t.rkd, t.sz)); end
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b0; pipe_tonext_valid_EX = 1'b0; pipe_valid_MEM = 1'b0; flush = 1'b0;
    pc_EX = '0; alu_result = '0; rkd_value = '0; dest = '0;
    byte_we = 1'b0; half_we = 1'b0; word_we = 1'b0; signed_we = 1'b0;
    res_from_mem = 1'b0; mem_we = 1'b0; gpr_we = 1'b0; ecode_EX_m = '0; EX_ex_ertn = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    last_rd = '0;
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_alu();
    test_flush_req();
    test_flush_wait();
    test_exception();
    test_reset_in_req();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
